mul_control: RTL and testbench
==============================

# mul_control

Sequencing controller for the shift-add multiplier datapath. It sits directly upstream of the product register and drives that register's load, write, shift and ready controls. It also generates the ALU add-enable from the product LSB and counts the WIDTH add/shift iterations. A start/ready/ack handshake lets a host launch one multiplication at a time and collect the result.

## Interface
- WIDTH, 32: operand width; the number of add/shift iterations.
- CW, $clog2(WIDTH+1): width of Count (derived; do not override).

- clk  input  1  clock; all state changes on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  request a new multiplication; sampled in IDLE and DONE.
- Ack  input  1  host has consumed the result; sampled in DONE.
- LSB  input  1  product register bit 0 (current multiplier bit).
- Prod_Load  output  1  product register load: upper half cleared, multiplier loaded into lower half. Wired to the product register's load/Reset input.
- W_ctrl  output  1  product register writes ALU result into its upper half.
- SRL_ctrl  output  1  product register shifts right by one, with ALU carry entering bit 2*WIDTH-1.
- Add_En  output  1  ALU adds multiplicand when 1; passes product upper half unchanged when 0.
- Ready  output  1  result valid in the product register; product register holds.
- Busy  output  1  multiplication in progress (LOAD or ITER).
- Count  output  CW  number of iterations completed in the current operation.

## Operation
- FSM states: IDLE, LOAD, ITER, DONE. Encoding is free. State and Count are registered.
- IDLE: all outputs 0. Start=1 -> LOAD.
- LOAD (exactly one cycle): Prod_Load=1, Busy=1, Count cleared to 0. -> ITER.
- ITER: W_ctrl=1, SRL_ctrl=1, Busy=1, Add_En=LSB (combinational from LSB, valid only in ITER; 0 elsewhere).
  - Count increments by 1 each cycle.
  - When Count==WIDTH-1 on the edge, Count becomes WIDTH and state -> DONE.
  - W_ctrl is 1 on every iteration, because the product register only shifts when written. The add/no-add decision is made solely through Add_En.
- DONE: Ready=1, W_ctrl=SRL_ctrl=Busy=0, and Count holds WIDTH.
  - Ack=1 and Start=0 -> IDLE.
  - Ack=1 and Start=1 -> LOAD (back-to-back operation).
  - Ack=0 -> stay in DONE; Start is ignored.
- Start is ignored in LOAD and ITER. There is no queuing: a Start pulse that arrives while Busy is lost.
- Ack is ignored outside DONE.
- Prod_Load, W_ctrl, SRL_ctrl, Ready and Busy are decoded from state only (Moore). They must never be simultaneously asserted in any combination other than W_ctrl+SRL_ctrl+Busy.
- Reset=1, asynchronous, at any time including mid-ITER: state -> IDLE, Count -> 0, all outputs 0 in the same instant, independent of clk. Operation resumes only on a Start after Reset is released.

## Timing
- Reset values: Prod_Load=0, W_ctrl=0, SRL_ctrl=0, Add_En=0, Ready=0, Busy=0, Count=0.
- With Start sampled high in IDLE at edge E0:
  - LOAD during cycle E0..E1.
  - ITER during cycles E1..E(WIDTH+1).
  - Ready rises after edge E(WIDTH+1).
  - Start-to-Ready latency = WIDTH+1 cycles.
- Add_En follows LSB within the same cycle. The product register samples the ALU result on the edge that ends each ITER cycle.
- Ready remains high for as long as Ack stays low. It falls on the edge where Ack=1 is sampled.
- Back-to-back throughput: one result every WIDTH+2 cycles (LOAD + WIDTH×ITER + one DONE cycle).
- Count is monotonic 0..WIDTH within an operation and never wraps.

## Test plan
- Reset asserted asynchronously between edges while in ITER with Count=17 -> all outputs and Count read 0 before the next clk edge. State IDLE after release, and no activity until Start.
- WIDTH=32, single Start pulse, LSB driven by a product-register model with multiplier 0xFFFFFFFF and multiplicand 0xFFFFFFFF:
  - Prod_Load high exactly 1 cycle.
  - W_ctrl=SRL_ctrl=1 for exactly 32 cycles.
  - Ready rises 33 cycles after Start is sampled.
  - Product = 0xFFFFFFFE00000001.
- Multiplier 0x00000005, multiplicand 0x00000003 -> Add_En high only on iterations 0 and 2 (Count=0,2); final product 0x000000000000000F.
- Start held high continuously during LOAD/ITER -> no restart and Count unaffected. Ack held low for 10 cycles in DONE -> Ready held, Count=32, no control strobes.
- Ack=1 and Start=1 together in DONE -> next state LOAD: Prod_Load=1 on the following cycle with Ready already 0, second result valid 34 cycles after the first Ready.
- Ack=1 with Start=0 in DONE -> IDLE. A spurious Ack later in IDLE produces no output change.

Source files
------------

// File: rtl/mul_control_if.sv
// Handshake and product-register control bundle between the host/datapath and mul_control.
interface mul_control_if #(
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic          Start;
  logic          Ack;
  logic          LSB;
  logic          Prod_Load;
  logic          W_ctrl;
  logic          SRL_ctrl;
  logic          Add_En;
  logic          Ready;
  logic          Busy;
  logic [CW-1:0] Count;

  modport master (
    output Start, Ack, LSB,
    input  Prod_Load, W_ctrl, SRL_ctrl, Add_En, Ready, Busy, Count
  );

  modport slave (
    input  Start, Ack, LSB,
    output Prod_Load, W_ctrl, SRL_ctrl, Add_En, Ready, Busy, Count
  );
endinterface

// File: rtl/mul_control.sv
// Sequencer for a shift-add multiplier: LOAD once, WIDTH add/shift iterations, then hold
// the result in DONE until the host acknowledges it.
module mul_control #(
  parameter int unsigned WIDTH = 32
) (
  input logic          clk,
  input logic          Reset,
  mul_control_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          load_q, load_d;
  logic          iter_q, iter_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;

  // Next state, iteration count and next-cycle strobes
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: if (bus.Start) state_d = LOAD;
      LOAD: state_d = ITER;
      ITER: begin
        count_d = CW'(count_q + CW'(1));
        if (count_q == CW'(WIDTH - 1)) state_d = DONE;
      end
      DONE: if (bus.Ack) state_d = bus.Start ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
    // Count reads 0 in IDLE and is cleared for every new operation
    if (state_d == IDLE || state_d == LOAD) count_d = '0;
    load_d  = (state_d == LOAD);
    iter_d  = (state_d == ITER);
    ready_d = (state_d == DONE);
    busy_d  = (state_d == LOAD) || (state_d == ITER);
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      count_q <= '0;
      load_q  <= 1'b0;
      iter_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      load_q  <= load_d;
      iter_q  <= iter_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Strobes come from flops that mirror the state; only Add_En passes LSB through
  assign bus.Prod_Load = load_q;
  assign bus.W_ctrl    = iter_q;
  assign bus.SRL_ctrl  = iter_q;
  assign bus.Add_En    = iter_q & bus.LSB;
  assign bus.Ready     = ready_q;
  assign bus.Busy      = busy_q;
  assign bus.Count     = count_q;
endmodule

// File: tb/tb_mul_control.sv
// Directed bench for mul_control with a behavioural shift-add product register driving LSB.
module tb_mul_control;
  localparam int unsigned WIDTH = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mplier = 32'h0;
  logic [31:0] mcand = 32'h0;
  logic [63:0] prod = 64'h0;
  int          total = 0;
  int          bad = 0;

  mul_control_if #(.WIDTH(WIDTH)) bus ();

  mul_control #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Product register: load multiplier, or write ALU result into the upper half and shift right
  always @(posedge clk) begin
    logic [32:0] sum;
    if (bus.Prod_Load) prod <= {32'h0, mplier};
    else if (bus.W_ctrl && bus.SRL_ctrl) begin
      sum = {1'b0, prod[63:32]} + (bus.Add_En ? {1'b0, mcand} : 33'h0);
      prod <= {sum, prod[31:1]};
    end
  end
  assign bus.LSB = prod[0];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] strobes();
    return {bus.Prod_Load, bus.W_ctrl, bus.SRL_ctrl, bus.Ready, bus.Busy};
  endfunction

  function automatic bit legal(logic [4:0] s);
    return (s == 5'b00000) || (s == 5'b10001) || (s == 5'b01101) || (s == 5'b00010);
  endfunction

  task automatic test_reset();
    bus.Start = 1'b0;
    bus.Ack   = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({strobes(), bus.Add_En} !== 6'b0) begin
      bad++;
      $display("FAIL reset_strobes got=%b want=000000", {strobes(), bus.Add_En});
    end
    total++;
    if (bus.Count !== 6'd0) begin
      bad++;
      $display("FAIL reset_count got=%0d want=0", bus.Count);
    end
    rst = 1'b0;
    tick();
    tick();
    total++;
    if ({strobes(), bus.Count} !== 11'b0) begin
      bad++;
      $display("FAIL idle_after_reset got=%b want=0", {strobes(), bus.Count});
    end
  endtask

  task automatic test_full_ones();
    int lat = 0, n_load = 0, n_iter = 0, n_illegal = 0;
    mplier = 32'hFFFF_FFFF;
    mcand  = 32'hFFFF_FFFF;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    while (!bus.Ready && lat < 100) begin
      if (bus.Prod_Load) n_load++;
      if (bus.W_ctrl && bus.SRL_ctrl) n_iter++;
      if (!legal(strobes())) n_illegal++;
      tick();
      lat++;
    end
    total++;
    if (n_load != 1) begin bad++; $display("FAIL ones_load_cycles got=%0d want=1", n_load); end
    total++;
    if (n_iter != 32) begin bad++; $display("FAIL ones_iter_cycles got=%0d want=32", n_iter); end
    total++;
    if (lat != 33) begin bad++; $display("FAIL ones_latency got=%0d want=33", lat); end
    total++;
    if (n_illegal != 0) begin bad++; $display("FAIL ones_strobe_combo got=%0d want=0", n_illegal); end
    total++;
    if (prod !== 64'hFFFF_FFFE_0000_0001) begin
      bad++;
      $display("FAIL ones_product got=%h want=fffffffe00000001", prod);
    end
    total++;
    if ({strobes(), bus.Count} !== {5'b00010, 6'd32}) begin
      bad++;
      $display("FAIL ones_done got=%b/%0d want=00010/32", strobes(), bus.Count);
    end
    bus.Ack = 1'b1;
    tick();
    bus.Ack = 1'b0;
    total++;
    if ({strobes(), bus.Add_En, bus.Count} !== 12'b0) begin
      bad++;
      $display("FAIL ones_ack_idle got=%b want=0", {strobes(), bus.Add_En, bus.Count});
    end
  endtask

  task automatic test_five_three();
    int    lat = 0;
    logic [63:0] mask = 64'h0;
    mplier = 32'h0000_0005;
    mcand  = 32'h0000_0003;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    while (!bus.Ready && lat < 100) begin
      if (bus.Add_En) mask = mask | (64'(1) << bus.Count);
      tick();
      lat++;
    end
    total++;
    if (mask !== 64'h5) begin bad++; $display("FAIL add_en_iters got=%h want=5", mask); end
    total++;
    if (prod !== 64'hF) begin bad++; $display("FAIL product_5x3 got=%h want=f", prod); end
    bus.Ack = 1'b1;
    tick();
    bus.Ack = 1'b0;
  endtask

  task automatic test_start_held();
    int lat = 0, n_load = 0, exp_cnt = 0;
    mplier = 32'h0000_0002;
    mcand  = 32'h0000_0004;
    bus.Start = 1'b1;
    tick();
    while (!bus.Ready && lat < 100) begin
      if (bus.Prod_Load) n_load++;
      if (bus.W_ctrl) begin
        total++;
        if (bus.Count !== 6'(exp_cnt)) begin
          bad++;
          $display("FAIL held_count got=%0d want=%0d", bus.Count, exp_cnt);
        end
        exp_cnt++;
      end
      tick();
      lat++;
    end
    total++;
    if (n_load != 1 || lat != 33) begin
      bad++;
      $display("FAIL held_no_restart got=load%0d/lat%0d want=load1/lat33", n_load, lat);
    end
    total++;
    if (prod !== 64'h8) begin bad++; $display("FAIL product_2x4 got=%h want=8", prod); end
    // Start still high while Ack stays low: DONE must hold
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if ({strobes(), bus.Add_En, bus.Count} !== {5'b00010, 1'b0, 6'd32}) begin
        bad++;
        $display("FAIL ack_hold cyc=%0d got=%b want=%b", i, {strobes(), bus.Add_En, bus.Count},
                 {5'b00010, 1'b0, 6'd32});
      end
    end
    bus.Start = 1'b0;
    bus.Ack   = 1'b1;
    tick();
    bus.Ack = 1'b0;
    total++;
    if ({strobes(), bus.Count} !== 11'b0) begin
      bad++;
      $display("FAIL held_ack_idle got=%b want=0", {strobes(), bus.Count});
    end
  endtask

  task automatic test_back_to_back();
    int lat = 0, n = 0;
    mplier = 32'h0000_0007;
    mcand  = 32'h0000_0009;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    while (!bus.Ready && lat < 100) begin
      tick();
      lat++;
    end
    total++;
    if (prod !== 64'h3F) begin bad++; $display("FAIL product_7x9 got=%h want=3f", prod); end
    mplier = 32'h1234_5678;
    mcand  = 32'h0000_0010;
    bus.Ack   = 1'b1;
    bus.Start = 1'b1;
    tick();
    n = 1;
    bus.Ack   = 1'b0;
    bus.Start = 1'b0;
    total++;
    if ({strobes(), bus.Count} !== {5'b10001, 6'd0}) begin
      bad++;
      $display("FAIL b2b_load got=%b want=%b", {strobes(), bus.Count}, {5'b10001, 6'd0});
    end
    while (!bus.Ready && n < 100) begin
      tick();
      n++;
    end
    total++;
    if (n != 34) begin bad++; $display("FAIL b2b_spacing got=%0d want=34", n); end
    total++;
    if (prod !== 64'h1_2345_6780) begin
      bad++;
      $display("FAIL b2b_product got=%h want=123456780", prod);
    end
    bus.Ack = 1'b1;
    tick();
    bus.Ack = 1'b0;
  endtask

  task automatic test_idle_ack();
    bus.Ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({strobes(), bus.Add_En, bus.Count} !== 12'b0) begin
        bad++;
        $display("FAIL idle_spurious_ack cyc=%0d got=%b want=0", i, {strobes(), bus.Add_En, bus.Count});
      end
    end
    bus.Ack = 1'b0;
  endtask

  task automatic test_async_reset();
    int guard = 0;
    mplier = 32'hA5A5_A5A5;
    mcand  = 32'h0000_0001;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    while (!(bus.W_ctrl && bus.Count == 6'd17) && guard < 60) begin
      tick();
      guard++;
    end
    total++;
    if (guard >= 60) begin bad++; $display("FAIL reach_count17 got=timeout want=count17"); end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({strobes(), bus.Add_En, bus.Count} !== 12'b0) begin
      bad++;
      $display("FAIL async_reset got=%b want=0", {strobes(), bus.Add_En, bus.Count});
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if ({strobes(), bus.Add_En, bus.Count} !== 12'b0) begin
        bad++;
        $display("FAIL post_reset_idle cyc=%0d got=%b want=0", i, {strobes(), bus.Add_En, bus.Count});
      end
    end
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    total++;
    if ({strobes(), bus.Count} !== {5'b10001, 6'd0}) begin
      bad++;
      $display("FAIL restart_load got=%b want=%b", {strobes(), bus.Count}, {5'b10001, 6'd0});
    end
  endtask

  initial begin
    bus.Start = 1'b0;
    bus.Ack   = 1'b0;
    test_reset();
    test_full_ones();
    test_five_three();
    test_start_held();
    test_back_to_back();
    test_idle_ack();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
